// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU board.
// Input channel map and conditioner defaults.
package cpu_pkg;

    localparam int CPU_IN_CHANNELS         = 8;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    localparam int CH_IN0  = 0;
    localparam int CH_IN1  = 1;
    localparam int CH_IN2  = 2;
    localparam int CH_IN3  = 3;
    localparam int CH_PROG = 4;
    localparam int CH_RX   = 6;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One input channel: synchronizer chain, debounce
// counter, registered level and edge pulses.
module input_conditioner_channel
    import cpu_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic pin_i,
    input  logic debounce_en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_nxt_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_en_d;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_sync;
    logic                   w_toggle;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_level_nxt;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_toggle = debounce_en_i ^ r_en_d;

    // Plain flop chain: nothing between stages.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_i};
        end
    end

    // Filter decision; a mode toggle restarts the count without
    // moving the level.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        if (!debounce_en_i) begin
            w_level_nxt = w_sync;
            w_cnt_nxt   = '0;
        end else if (w_sync == r_level) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_level_nxt = w_sync;
            w_cnt_nxt   = '0;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
        if (w_toggle) begin
            w_cnt_nxt   = '0;
            w_level_nxt = r_level;
        end
    end

    // Level, counter and mode history.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt   <= '0;
            r_level <= RESET_VAL;
            r_en_d  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_en_d  <= debounce_en_i;
        end
    end

    // Edge pulses from level against its delayed copy.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_level_d <= RESET_VAL;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            r_fall    <= ~r_level & r_level_d;
        end
    end

    assign level_o    = r_level;
    assign rise_o     = r_rise;
    assign fall_o     = r_fall;
    assign edge_nxt_o = r_level ^ r_level_d;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input front end: one conditioner per pin
// plus a registered any-edge summary.
module input_conditioner
    import cpu_pkg::*;
#(
    parameter int CHANNELS        = CPU_IN_CHANNELS,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [CHANNELS-1:0] input_i,
    input  logic [CHANNELS-1:0] debounce_en_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                any_change_o
);

    logic [CHANNELS-1:0] w_edge_nxt;
    logic                r_any;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        input_conditioner_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (RESET_VALUE[k])
        ) u_ch (
            .clk_i        (clk_i),
            .reset_ni     (reset_ni),
            .pin_i        (input_i[k]),
            .debounce_en_i(debounce_en_i[k]),
            .level_o      (level_o[k]),
            .rise_o       (rise_o[k]),
            .fall_o       (fall_o[k]),
            .edge_nxt_o   (w_edge_nxt[k])
        );
    end

    // Summary flag updates on the same edge as the pulses.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_edge_nxt;
        end
    end

    assign any_change_o = r_any;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: reset, debounce,
// glitch, bypass, mode toggle, simultaneous edges, async reset.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       reset_ni;
    logic [7:0] input_i;
    logic [7:0] debounce_en_i;
    logic [7:0] level_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic       any_change_o;

    int errors = 0;
    int checks = 0;

    input_conditioner #(
        .CHANNELS       (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .RESET_VALUE    (8'h20)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .input_i      (input_i),
        .debounce_en_i(debounce_en_i),
        .level_o      (level_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .any_change_o (any_change_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pin_pat(input int e);
        if (e < 1) return 1'b0;
        return (((e - 1) / 3) % 2) == 0;
    endfunction

    task automatic test_reset();
        logic [7:0] exp_lvl;
        logic [7:0] exp_fall;
        reset_ni      = 1'b0;
        input_i       = 8'h00;
        debounce_en_i = 8'hBF;
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (level_o !== 8'h20) begin
                errors++;
                $display("FAIL rst_level got=%h exp=20", level_o);
            end
            checks++;
            if ({rise_o, fall_o, any_change_o} !== 17'h0) begin
                errors++;
                $display("FAIL rst_pulse got=%h/%h/%b exp=0",
                         rise_o, fall_o, any_change_o);
            end
        end
        reset_ni = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_lvl  = (e >= 18) ? 8'h00 : 8'h20;
            exp_fall = (e == 19) ? 8'h20 : 8'h00;
            checks++;
            if (level_o !== exp_lvl) begin
                errors++;
                $display("FAIL rel_level e=%0d got=%h exp=%h",
                         e, level_o, exp_lvl);
            end
            checks++;
            if (fall_o !== exp_fall || rise_o !== 8'h00) begin
                errors++;
                $display("FAIL rel_edge e=%0d fall=%h rise=%h exp=%h/00",
                         e, fall_o, rise_o, exp_fall);
            end
            checks++;
            if (any_change_o !== (e == 19)) begin
                errors++;
                $display("FAIL rel_any e=%0d got=%b exp=%b",
                         e, any_change_o, (e == 19));
            end
        end
    endtask

    task automatic test_debounce_rise();
        input_i[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (level_o[0] !== (e >= 18)) begin
                errors++;
                $display("FAIL deb_level e=%0d got=%b exp=%b",
                         e, level_o[0], (e >= 18));
            end
            checks++;
            if (rise_o[0] !== (e == 19)) begin
                errors++;
                $display("FAIL deb_rise e=%0d got=%b exp=%b",
                         e, rise_o[0], (e == 19));
            end
        end
        input_i[0] = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_glitch();
        input_i[0] = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            tick();
            if (e == 15) input_i[0] = 1'b0;
            if (e == 16) input_i[0] = 1'b1;
            checks++;
            if (level_o[0] !== (e >= 34)) begin
                errors++;
                $display("FAIL glitch_level e=%0d got=%b exp=%b",
                         e, level_o[0], (e >= 34));
            end
            checks++;
            if (rise_o[0] !== (e == 35)) begin
                errors++;
                $display("FAIL glitch_rise e=%0d got=%b exp=%b",
                         e, rise_o[0], (e == 35));
            end
        end
        input_i[0] = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_bypass();
        logic lv0;
        logic lv1;
        logic lv2;
        for (int e = 1; e <= 24; e++) begin
            input_i[6] = pin_pat(e);
            tick();
            lv0 = pin_pat(e - 2);
            lv1 = pin_pat(e - 3);
            lv2 = pin_pat(e - 4);
            checks++;
            if (level_o[6] !== lv0) begin
                errors++;
                $display("FAIL byp_level e=%0d got=%b exp=%b",
                         e, level_o[6], lv0);
            end
            checks++;
            if (rise_o[6] !== (lv1 & ~lv2) ||
                fall_o[6] !== (~lv1 & lv2)) begin
                errors++;
                $display("FAIL byp_edge e=%0d got=%b%b exp=%b%b",
                         e, rise_o[6], fall_o[6],
                         lv1 & ~lv2, ~lv1 & lv2);
            end
            checks++;
            if (any_change_o !== (lv1 ^ lv2)) begin
                errors++;
                $display("FAIL byp_any e=%0d got=%b exp=%b",
                         e, any_change_o, lv1 ^ lv2);
            end
        end
        input_i[6] = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_mode_toggle();
        input_i[1] = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            if (e == 13) debounce_en_i[1] = 1'b0;
            if (e == 14) debounce_en_i[1] = 1'b1;
            tick();
            checks++;
            if (level_o[1] !== (e >= 30)) begin
                errors++;
                $display("FAIL mode_level e=%0d got=%b exp=%b",
                         e, level_o[1], (e >= 30));
            end
            checks++;
            if (rise_o[1] !== (e == 31)) begin
                errors++;
                $display("FAIL mode_rise e=%0d got=%b exp=%b",
                         e, rise_o[1], (e == 31));
            end
        end
        input_i[1] = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rise;
        logic [1:0] exp_lvl;
        input_i[3:2] = 2'b11;
        for (int e = 1; e <= 21; e++) begin
            tick();
            exp_rise = (e == 19) ? 8'h0C : 8'h00;
            exp_lvl  = (e >= 18) ? 2'b11 : 2'b00;
            checks++;
            if (level_o[3:2] !== exp_lvl) begin
                errors++;
                $display("FAIL b2b_level e=%0d got=%b exp=%b",
                         e, level_o[3:2], exp_lvl);
            end
            checks++;
            if (rise_o !== exp_rise) begin
                errors++;
                $display("FAIL b2b_rise e=%0d got=%h exp=%h",
                         e, rise_o, exp_rise);
            end
            checks++;
            if (any_change_o !== (e == 19)) begin
                errors++;
                $display("FAIL b2b_any e=%0d got=%b exp=%b",
                         e, any_change_o, (e == 19));
            end
        end
    endtask

    task automatic test_async_reset();
        input_i[0] = 1'b1;
        repeat (14) tick();
        #2;
        reset_ni = 1'b0;
        #1;
        checks++;
        if (level_o !== 8'h20) begin
            errors++;
            $display("FAIL arst_level got=%h exp=20", level_o);
        end
        checks++;
        if ({rise_o, fall_o, any_change_o} !== 17'h0) begin
            errors++;
            $display("FAIL arst_pulse got=%h/%h/%b exp=0",
                     rise_o, fall_o, any_change_o);
        end
        repeat (2) tick();
        reset_ni = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            tick();
            checks++;
            if (level_o !== 8'h20) begin
                errors++;
                $display("FAIL arst_rel_level e=%0d got=%h exp=20",
                         e, level_o);
            end
            checks++;
            if ({rise_o, fall_o, any_change_o} !== 17'h0) begin
                errors++;
                $display("FAIL arst_rel_pulse e=%0d got=%h/%h/%b exp=0",
                         e, rise_o, fall_o, any_change_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce_rise();
        test_glitch();
        test_bypass();
        test_mode_toggle();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
